// File: rtl/eo_frame_counter.sv
// Counts even and odd samples over a valid/ready input frame and reports
// the totals, a saturation flag and a 4-bit frame id on a valid/ready output.
module eo_frame_counter #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_num,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_even_cnt,
  output logic [CNT_W-1:0]  out_odd_cnt,
  output logic              out_sat,
  output logic [3:0]        out_frame_id
);

  typedef enum logic {ACCUM, REPORT} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic             rdy_q, rdy_d;
  logic [CNT_W-1:0] even_q, even_d, odd_q, odd_d;
  logic             sat_q, sat_d;
  logic             ov_q, ov_d;
  logic [CNT_W-1:0] oe_q, oe_d, oo_q, oo_d;
  logic             os_q, os_d;
  logic [3:0]       id_q, id_d;

  logic             accept;
  logic [CNT_W-1:0] even_n, odd_n;
  logic             sat_n;

  // Only the LSB decides parity; the rest of the sample is intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^in_num[DATA_W-1:1];

  assign accept = in_valid && rdy_q && (state_q == ACCUM);

  // Counters including the current sample, saturating instead of wrapping
  always_comb begin
    even_n = even_q;
    odd_n  = odd_q;
    sat_n  = sat_q;
    if (accept) begin
      if (in_num[0]) begin
        if (odd_q == CNT_MAX) sat_n = 1'b1;
        else                  odd_n = odd_q + CNT_W'(1);
      end else begin
        if (even_q == CNT_MAX) sat_n = 1'b1;
        else                   even_n = even_q + CNT_W'(1);
      end
    end
  end

  // Next-state and register update logic
  always_comb begin
    state_d = state_q;
    even_d  = even_q;
    odd_d   = odd_q;
    sat_d   = sat_q;
    ov_d    = ov_q;
    oe_d    = oe_q;
    oo_d    = oo_q;
    os_d    = os_q;
    id_d    = id_q;
    unique case (state_q)
      ACCUM: begin
        if (accept) begin
          even_d = even_n;
          odd_d  = odd_n;
          sat_d  = sat_n;
          if (in_last) begin
            oe_d    = even_n;
            oo_d    = odd_n;
            os_d    = sat_n;
            ov_d    = 1'b1;
            state_d = REPORT;
          end
        end
      end
      REPORT: begin
        if (ov_q && out_ready) begin
          even_d  = '0;
          odd_d   = '0;
          sat_d   = 1'b0;
          ov_d    = 1'b0;
          id_d    = id_q + 4'(1);
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
    rdy_d = (state_d == ACCUM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      rdy_q   <= 1'b0;
      even_q  <= '0;
      odd_q   <= '0;
      sat_q   <= 1'b0;
      ov_q    <= 1'b0;
      oe_q    <= '0;
      oo_q    <= '0;
      os_q    <= 1'b0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      even_q  <= even_d;
      odd_q   <= odd_d;
      sat_q   <= sat_d;
      ov_q    <= ov_d;
      oe_q    <= oe_d;
      oo_q    <= oo_d;
      os_q    <= os_d;
      id_q    <= id_d;
    end
  end

  assign in_ready     = rdy_q;
  assign out_valid    = ov_q;
  assign out_even_cnt = oe_q;
  assign out_odd_cnt  = oo_q;
  assign out_sat      = os_q;
  assign out_frame_id = id_q;

endmodule
